// File: rtl/input_arbiter_pkg.sv
// Shared definitions for the PLC input register bank arbiter.
//   state_e        : controller states (BOOT, LOAD, RUN)
//   DEFAULT_ADDR_W : default input bit address width
//   INPUT_BANK_W   : width of the input register bank
//   CNT_W          : width of the optional contention counter
package input_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int DEFAULT_ADDR_W = 4;
  localparam int INPUT_BANK_W   = 16;
  localparam int CNT_W          = 16;

endpackage

// File: rtl/input_register_arbiter_rr_arbiter.sv
// rr_arbiter: purely combinational one-hot round-robin pick.
// The search starts at ptr_i and wraps upward through the request vector.
// Ports:
//   req_i [NUM_CORES] : request vector
//   ptr_i [PTR_W]     : index with highest priority this cycle
//   gnt_o [NUM_CORES] : one-hot grant, zero when no request is set
module rr_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int PTR_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0] req_i,
  input  logic [PTR_W-1:0]     ptr_i,
  output logic [NUM_CORES-1:0] gnt_o
);

  logic [2*NUM_CORES-1:0] req_dbl;
  logic [NUM_CORES-1:0]   req_rot;
  logic [NUM_CORES-1:0]   pick_rot;

  always_comb begin
    // Rotate right so the pointer position lands on bit 0.
    req_dbl  = {req_i, req_i};
    req_rot  = NUM_CORES'(req_dbl >> ptr_i);
    // Isolate the lowest set bit: first requester at or after the pointer.
    pick_rot = req_rot & (~req_rot + NUM_CORES'(1));
    // Rotate back: right shift by (NUM_CORES - ptr) equals left rotate by ptr.
    gnt_o    = NUM_CORES'({pick_rot, pick_rot} >> (NUM_CORES - int'(ptr_i)));
  end

endmodule

// File: rtl/input_register_arbiter.sv
// input_register_arbiter: controller and round-robin arbiter sharing the
// single bit-read port of the PLC input register bank among NUM_CORES cores.
// It also sequences the input snapshot (LoadInput pulse after reset and on
// every scan-start request), blocking core reads in the load cycle.
// Optional feature macro: INPUT_ARBITER_CONTENTION_CNT_EN adds a saturating
// 16-bit count of cycles in which some asserted request went ungranted.
// Ports:
//   CLK, RST                   : clock, synchronous active-high reset
//   INPUTARBITER_ScanStart     : one-cycle request for a new snapshot
//   INPUTARBITER_ScanBusy      : high in BOOT and LOAD
//   INPUTARBITER_Req/Addr      : per-core read request and bit address
//   INPUTARBITER_Gnt           : combinational one-hot grant
//   INPUTARBITER_RdValid/Data  : registered per-core read return
//   INPUTARBITER_RegEN/LoadInput/InADDR/InDATA : bank interface
//   INPUTARBITER_ContentionCnt : (optional) contention counter
module input_register_arbiter
  import input_arbiter_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = DEFAULT_ADDR_W
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        INPUTARBITER_ScanStart,
  output logic                        INPUTARBITER_ScanBusy,
  input  logic [NUM_CORES-1:0]        INPUTARBITER_Req,
  input  logic [NUM_CORES*ADDR_W-1:0] INPUTARBITER_Addr,
  output logic [NUM_CORES-1:0]        INPUTARBITER_Gnt,
  output logic [NUM_CORES-1:0]        INPUTARBITER_RdValid,
  output logic [NUM_CORES-1:0]        INPUTARBITER_RdData,
  output logic                        INPUTARBITER_RegEN,
  output logic                        INPUTARBITER_RegLoadInput,
  output logic [ADDR_W-1:0]           INPUTARBITER_RegInADDR,
  input  logic                        INPUTARBITER_RegInDATA
`ifdef INPUT_ARBITER_CONTENTION_CNT_EN
  ,
  output logic [CNT_W-1:0]            INPUTARBITER_ContentionCnt
`endif
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  state_e               state_q;
  logic                 busy_q;
  logic                 load_q;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [NUM_CORES-1:0] rdvalid_q;
  logic [NUM_CORES-1:0] rddata_q, rddata_d;
  logic [NUM_CORES-1:0] rr_gnt;
  logic [NUM_CORES-1:0] gnt;
  logic [ADDR_W-1:0]    addr_sel;

  rr_arbiter #(
    .NUM_CORES (NUM_CORES),
    .PTR_W     (PTR_W)
  ) u_rr (
    .req_i (INPUTARBITER_Req),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt)
  );

  // Grant path: only RUN may grant; selects address, next pointer and read bit.
  always_comb begin
    gnt      = (state_q == ST_RUN) ? rr_gnt : '0;
    addr_sel = '0;
    ptr_d    = ptr_q;
    rddata_d = rddata_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (gnt[i]) begin
        addr_sel    = INPUTARBITER_Addr[ADDR_W*i +: ADDR_W];
        ptr_d       = PTR_W'((i + 1) % NUM_CORES);
        rddata_d[i] = INPUTARBITER_RegInDATA;
      end
    end
  end

  // Controller FSM: ScanBusy and LoadInput are registered alongside the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_BOOT;
      busy_q  <= 1'b1;
      load_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q <= ST_LOAD;
          busy_q  <= 1'b1;
          load_q  <= 1'b1;
        end
        ST_LOAD: begin
          // A ScanStart seen here is intentionally dropped.
          state_q <= ST_RUN;
          busy_q  <= 1'b0;
          load_q  <= 1'b0;
        end
        ST_RUN: begin
          if (INPUTARBITER_ScanStart) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
            load_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
            load_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_BOOT;
          busy_q  <= 1'b1;
          load_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read return and pointer; reset discards any grant of the reset cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q     <= '0;
      rdvalid_q <= '0;
      rddata_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      rdvalid_q <= gnt;
      rddata_q  <= rddata_d;
    end
  end

`ifdef INPUT_ARBITER_CONTENTION_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any waiting requester counts, whatever the state; saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (|(INPUTARBITER_Req & ~gnt) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign INPUTARBITER_ContentionCnt = cnt_q;
`endif

  assign INPUTARBITER_Gnt          = gnt;
  assign INPUTARBITER_ScanBusy     = busy_q;
  assign INPUTARBITER_RegLoadInput = load_q;
  assign INPUTARBITER_RegEN        = |gnt;
  assign INPUTARBITER_RegInADDR    = addr_sel;
  assign INPUTARBITER_RdValid      = rdvalid_q;
  assign INPUTARBITER_RdData       = rddata_q;

endmodule

// File: doc/input_register_arbiter.md
# input_register_arbiter

Controller and round-robin arbiter for the 16-bit input register bank of the multicore PLC. It shares the bank's single bit-read port among `NUM_CORES` PLC cores. It also sequences the input snapshot: a one-cycle `LoadInput` pulse after reset and on every scan-start request, with all core reads blocked during that cycle. It sits between the core array and the input register bank and is the only driver of the bank's EN, LoadInput and InADDR pins.

## Interface
Parameters:
- `NUM_CORES`, 4: number of requesting cores, 2..8.
- `ADDR_W`, 4: input bit address width; the bank has 2^ADDR_W bits.

Ports (name, direction, width, meaning):
- `CLK` in 1: clock. All logic uses the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `INPUTARBITER_ScanStart` in 1: one-cycle pulse requesting a new input snapshot.
- `INPUTARBITER_ScanBusy` out 1: high while the arbiter is in BOOT or LOAD.
- `INPUTARBITER_Req` in NUM_CORES: per-core read request, held until granted.
- `INPUTARBITER_Addr` in NUM_CORES*ADDR_W: per-core bit address; core i uses `[ADDR_W*i +: ADDR_W]`.
- `INPUTARBITER_Gnt` out NUM_CORES: one-hot grant, combinational, at most one bit set.
- `INPUTARBITER_RdValid` out NUM_CORES: registered; bit i high for one cycle after core i was granted.
- `INPUTARBITER_RdData` out NUM_CORES: registered read bit for each core; bit i holds its value until core i's next RdValid.
- `INPUTARBITER_RegEN` out 1: bank read enable. Equals OR of Gnt.
- `INPUTARBITER_RegLoadInput` out 1: bank snapshot load strobe.
- `INPUTARBITER_RegInADDR` out ADDR_W: address of the granted core; 0 when there is no grant.
- `INPUTARBITER_RegInDATA` in 1: bank read bit.

## Operation
State machine with three states: BOOT, LOAD, RUN.
- **Reset.** `RST` puts the state in BOOT and the round-robin pointer at 0. RdValid and RdData are cleared.
- **BOOT.** All outputs are 0 except ScanBusy=1. Moves to LOAD unconditionally.
- **LOAD.**
  - RegLoadInput=1, RegEN=0, Gnt=0, ScanBusy=1.
  - Moves to RUN unconditionally.
  - ScanStart received in LOAD is ignored and not queued.
- **RUN.**
  - Round-robin grant among the asserted Req bits, searching from the pointer upward with wrap-around.
  - Drives RegEN=1 and RegInADDR = granted core's address.
  - On a grant, the pointer moves to (granted index + 1) mod NUM_CORES. With no grant, the pointer holds.
  - ScanStart=1 at a RUN clock edge moves the state to LOAD. Grants in that same cycle still proceed and return the old snapshot.
- **Core handshake.**
  - A core holds Req and Addr stable until it sees its Gnt bit at a clock edge.
  - It may drop Req or change Addr in the following cycle.
  - A core that keeps Req high is re-arbitrated as a new request.
- **Read return.** At the edge ending a grant cycle, RegInDATA is registered into RdData[i] and RdValid[i] goes high for exactly one cycle.
- **Snapshot consistency.** Because no grant can occur in LOAD, every read either precedes the load edge (old snapshot) or follows it (new snapshot). No read ever sees a partial update.
- **Reset mid-operation.** An in-flight grant is discarded and no RdValid follows it. The sequence restarts at BOOT, then LOAD.

## Timing
- Uncontested read: Gnt in cycle t, RdValid and RdData in cycle t+1.
- Worst-case wait from Req assertion to Gnt: NUM_CORES-1 cycles, plus 1 if a LOAD intervenes.
- Scan snapshot: ScanStart sampled at edge e, LoadInput high in cycle e+1, new data readable from cycle e+2.
- After RST is released: BOOT 1 cycle, then LOAD 1 cycle; the first grant is possible in the 3rd cycle.

## Configuration
- `INPUT_ARBITER_CONTENTION_CNT_EN` defined:
  - Adds output `INPUTARBITER_ContentionCnt` [15:0]. Reset value 0.
  - Increments by 1 on every cycle in which at least one asserted Req bit is not granted, including LOAD cycles.
  - Saturates at 16'hFFFF.
- Not defined: the port and its counter do not exist, and all other behaviour is identical.

## Structure
- Package `input_arbiter_pkg` holds:
  - the state enum (BOOT, LOAD, RUN);
  - the default ADDR_W constant;
  - the input bank width constant 16;
  - the counter width constant 16.
- One sub-module, `rr_arbiter`: parameterised NUM_CORES, one-hot round-robin pick from a request vector and a pointer, purely combinational. The pointer register stays in the top level.

## Test plan
- **Reset sequence:** release RST → BOOT then LOAD (RegLoadInput=1 for exactly 1 cycle, ScanBusy=1 for 2 cycles), then RUN with ScanBusy=0.
- **Single read:** core 2 requests Addr=4'hA with bank bit 10 = 1 → Gnt=4'b0100 in the same cycle, RegInADDR=4'hA, RdValid[2]=1 and RdData[2]=1 the next cycle.
- **Full contention:** all four Req held high for 8 cycles from pointer 0 → grant order 0,1,2,3,0,1,2,3. With the macro defined, ContentionCnt=8.
- **Scan collision:** ScanStart and Req[1] both asserted in cycle t → core 1 granted in t and reads the old snapshot. LOAD in t+1 with no grant; a Req[1] held into t+1 is granted in t+2 and reads the new snapshot.
- **ScanStart during LOAD:** a second ScanStart pulse in the LOAD cycle → no second LoadInput pulse.
- **Reset mid-read:** RST asserted in a grant cycle → RdValid stays 0 and RdData is cleared; the sequence then replays BOOT → LOAD and the pointer is 0.
